iob_fifo_rd_burst_ctrl: RTL and testbench

Read-side controller for the synchronous asymmetric FIFO. It watches the FIFO occupancy, decides when to start a burst, drives `read_en` and absorbs the FIFO's one-cycle read latency. Words go out on a valid/ready stream, with `m_last` marking the end of each burst. It sits between the FIFO read port and a burst-oriented consumer such as a DMA or bus master. It is the FIFO's only reader.

---
 rtl/iob_fifo_rd_burst_ctrl.sv | 137 +++++++++++++
 tb/tb_iob_fifo_rd_burst_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_rd_burst_ctrl.sv
// Read-side burst controller for the asymmetric FIFO: schedules bursts from the
// occupancy level, issues FIFO reads and re-times the data onto a valid/ready stream.
module iob_fifo_rd_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [LEN_W-1:0]  cfg_burst_len,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic [31:0]       fifo_ocupancy,
    input  logic              fifo_empty,
    output logic              fifo_read_en,
    input  logic [DATA_W-1:0] fifo_r_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy
);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_BURST = 1'b1;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    logic [0:0]        state;
    logic [LEN_W-1:0]  burst_len;
    logic [LEN_W-1:0]  n_len;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  out_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rd_pend;
    logic [DATA_W-1:0] buf_mem [2];
    logic              buf_wr_ptr;
    logic              buf_rd_ptr;
    logic [1:0]        buf_cnt;
    logic [1:0]        committed;
    logic              occ_nonzero;
    logic              occ_ge_len;
    logic              tmo_hit;
    logic              start;
    logic              pop;

    // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
    always_comb begin
        burst_len = cfg_burst_len;
        if (cfg_burst_len == '0) begin
            burst_len = LEN_ONE;
        end
    end

    assign occ_nonzero = (fifo_ocupancy != 32'd0);
    assign occ_ge_len  = (fifo_ocupancy >= 32'(burst_len));
    assign tmo_hit     = (cfg_timeout != '0) && (tmo_cnt == cfg_timeout) && occ_nonzero;
    assign start       = (state == S_IDLE) && cfg_en && (occ_ge_len || tmo_hit);

    assign busy    = (state == S_BURST);
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_mem[buf_rd_ptr];
    assign m_last  = m_valid && (out_cnt == n_len - LEN_ONE);
    assign pop     = m_valid && m_ready;

    // Slots already claimed once this cycle's pop leaves: keeps 1 word/cycle
    // with m_ready high while never overfilling the 2-entry buffer.
    assign committed    = buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
    assign fifo_read_en = (state == S_BURST) && (issue_cnt < n_len) && !fifo_empty
                          && (committed < 2'd2);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            n_len     <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= fifo_read_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_BURST;
                        n_len     <= occ_ge_len ? burst_len : fifo_ocupancy[LEN_W-1:0];
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                    end
                end
                default: begin
                    if (fifo_read_en) begin
                        issue_cnt <= issue_cnt + LEN_ONE;
                    end
                    if (pop) begin
                        out_cnt <= out_cnt + LEN_ONE;
                        if (m_last) begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == S_BURST || !occ_nonzero || cfg_timeout == '0) begin
            tmo_cnt <= '0;
        end else if (!occ_ge_len && tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
        end
    end

    // NOTE: the two buffer words are reset so m_data reads 0 while reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            buf_wr_ptr <= 1'b0;
            buf_rd_ptr <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (rd_pend) begin
                buf_mem[buf_wr_ptr] <= fifo_r_data;
                buf_wr_ptr          <= ~buf_wr_ptr;
            end
            if (pop) begin
                buf_rd_ptr <= ~buf_rd_ptr;
            end
            buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_iob_fifo_rd_burst_ctrl.sv
// Scoreboard bench for iob_fifo_rd_burst_ctrl: a behavioural FIFO feeds the DUT,
// directed tests queue the expected words and a negedge monitor compares them.
module tb_iob_fifo_rd_burst_ctrl;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;
    localparam int TMO_W  = 8;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_en = 1'b0;
    logic [LEN_W-1:0]  cfg_burst_len = '0;
    logic [TMO_W-1:0]  cfg_timeout = '0;
    logic [31:0]       fifo_ocupancy = '0;
    logic              fifo_empty = 1'b1;
    logic              fifo_read_en;
    logic [DATA_W-1:0] fifo_r_data = '0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready = 1'b0;
    logic              busy;

    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] model_q[$];
    exp_t              sb[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                rd_issued = 0;
    int                hs_total = 0;

    iob_fifo_rd_burst_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_en        (cfg_en),
        .cfg_burst_len (cfg_burst_len),
        .cfg_timeout   (cfg_timeout),
        .fifo_ocupancy (fifo_ocupancy),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .fifo_r_data   (fifo_r_data),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous FIFO with one-cycle read latency, reset together with the DUT.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_q.delete();
                fifo_ocupancy <= '0;
                fifo_empty    <= 1'b1;
                fifo_r_data   <= '0;
            end else begin
                if (fifo_read_en && model_q.size() > 0) begin
                    fifo_r_data <= model_q.pop_front();
                end
                if (wr_en) begin
                    model_q.push_back(wr_data);
                end
                fifo_ocupancy <= 32'(model_q.size());
                fifo_empty    <= (model_q.size() == 0);
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and watches read/stall rules.
    initial begin
        logic prev_stall;
        exp_t prev_word;
        exp_t e;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rd_issued  = 0;
                hs_total   = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_word.last, prev_word.data});
                end
                if (m_valid && m_ready) begin
                    hs_total++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got %0h last %0b expected none", m_data, m_last);
                    end else begin
                        e = sb.pop_front();
                        check("word", {m_last, m_data}, {e.last, e.data});
                    end
                end
                if (fifo_read_en) begin
                    rd_issued++;
                    check("read_not_empty", fifo_empty, 0);
                    check("outstanding_le_2", (rd_issued - hs_total) <= 2, 1);
                end
                prev_stall = m_valid && !m_ready;
                prev_word  = {m_last, m_data};
            end
        end
    end

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic l);
        sb.push_back({l, d});
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, n < budget, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        bit pat [5];
        int n;
        int r0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_read_en", fifo_read_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_read_en", fifo_read_en, 0);
        check("post_rst_busy", busy, 0);

        // Full bursts: L=4, ten words -> two bursts, two words left behind
        cfg_en = 1'b1;
        cfg_burst_len = 8'd4;
        cfg_timeout = 8'd0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(16'h1000 + 16'(i), (i % 4) == 3);
        for (int i = 0; i < 10; i++) write_word(16'h1000 + 16'(i));
        wait_done("b_done", 200);
        r0 = rd_issued;
        repeat (10) @(negedge clk);
        check("b_no_third_burst", rd_issued - r0, 0);
        check("b_occupancy", fifo_ocupancy, 2);
        check("b_idle", busy, 0);
        do_reset();

        // Timeout flush: L=8, timeout=5, three words
        cfg_burst_len = 8'd8;
        cfg_timeout = 8'd5;
        for (int i = 0; i < 3; i++) push_exp(16'h2000 + 16'(i), i == 2);
        for (int i = 0; i < 3; i++) write_word(16'h2000 + 16'(i));
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("c_start_latency", n, 5);
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("c_first_word_latency", n, 2);
        wait_done("c_done", 200);
        check("c_occupancy", fifo_ocupancy, 0);

        // Backpressure: L=6, m_ready pattern 1,0,0,1,0
        cfg_timeout = 8'd0;
        cfg_burst_len = 8'd6;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_exp(16'h3A00 + 16'(i * 7), i == 5);
        for (int i = 0; i < 6; i++) write_word(16'h3A00 + 16'(i * 7));
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            m_ready = pat[n % 5];
            @(posedge clk);
            #1;
            n++;
        end
        check("d_done", n < 300, 1);
        m_ready = 1'b1;

        // Disable during word 2 and shorten the burst
        cfg_burst_len = 8'd4;
        for (int i = 0; i < 4; i++) push_exp(16'h4000 + 16'(i), i == 3);
        for (int i = 4; i < 8; i++) push_exp(16'h4000 + 16'(i), (i % 2) == 1);
        for (int i = 0; i < 4; i++) write_word(16'h4000 + 16'(i));
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("e_first_word_seen", n < 50, 1);
        @(posedge clk);
        #1;
        cfg_en = 1'b0;
        cfg_burst_len = 8'd2;
        for (int i = 4; i < 8; i++) write_word(16'h4000 + 16'(i));
        n = 0;
        while ((sb.size() != 4 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("e_first_burst_done", n < 100, 1);
        r0 = rd_issued;
        repeat (15) @(negedge clk);
        check("e_no_burst_disabled", rd_issued - r0, 0);
        check("e_occupancy_held", fifo_ocupancy, 4);
        @(posedge clk);
        #1;
        cfg_en = 1'b1;
        wait_done("e_done", 200);
        check("e_occupancy_end", fifo_ocupancy, 0);

        // Zero length -> 1-word bursts
        cfg_burst_len = 8'd0;
        for (int i = 0; i < 3; i++) push_exp(16'h5000 + 16'(i), 1'b1);
        for (int i = 0; i < 3; i++) write_word(16'h5000 + 16'(i));
        wait_done("f_done", 200);
        check("f_occupancy", fifo_ocupancy, 0);

        // Reset mid-burst with words buffered
        cfg_burst_len = 8'd8;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(16'h6000 + 16'(i));
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("g_burst_started", n < 50, 1);
        repeat (8) @(negedge clk);
        check("g_buffered_valid", m_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("g_rst_m_valid", m_valid, 0);
        check("g_rst_m_data", m_data, 0);
        check("g_rst_m_last", m_last, 0);
        check("g_rst_read_en", fifo_read_en, 0);
        check("g_rst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        r0 = rd_issued;
        repeat (10) @(negedge clk);
        check("g_no_read_after_rst", rd_issued - r0, 0);
        check("g_idle_after_rst", busy, 0);
        check("g_occupancy_after_rst", fifo_ocupancy, 0);
        check("g_scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
